// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and data-memory signals shared by the pipeline, the lsu_ctrl and the memory.
interface lsu_ctrl_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_err;
    logic [XLEN-1:0] resp_rdata;
    logic            mem_we;
    logic [XLEN-1:0] mem_a;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller for a word-only synchronous-read memory, sub-word stores via read-modify-write.
// Define LSU_ERR_EN to report misaligned/illegal requests through resp_err instead of coercing them.
module lsu_ctrl (
    input  logic       clk,
    input  logic       reset,
    lsu_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, LDRESP, RESP, ERR} state_t;
    state_t      r_state, w_next;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic        w_accept, w_req_err;
    logic [1:0]  w_req_size;
    logic [4:0]  w_shift;
    logic [31:0] w_mask, w_lane, w_load, w_merge;
    assign w_accept = bus.req_valid && bus.req_ready;
    // size: 0 byte, 1 half, 2 word; illegal encodings fall through to word
    assign w_req_size = (bus.req_funct3[1:0] == 2'b00 && !(bus.req_we && bus.req_funct3[2])) ? 2'd0 :
                        (bus.req_funct3[1:0] == 2'b01 && !(bus.req_we && bus.req_funct3[2])) ? 2'd1 : 2'd2;
`ifdef LSU_ERR_EN
    assign w_req_err = (bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                                   : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11))
                    || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                    || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign w_req_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_funct3[2];
                r_size  <= w_req_size;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_req_err ? ERR : (!bus.req_we || w_req_size != 2'd2) ? RD : WR;
            RD:      w_next = r_we ? WR : LDRESP;
            WR:      w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    // halfword lane uses addr[1] only, so a stray addr[0] never shifts data
    assign w_shift = r_size == 2'd0 ? {r_addr[1:0], 3'b000} : r_size == 2'd1 ? {r_addr[1], 4'b0000} : 5'd0;
    assign w_mask  = (r_size == 2'd0 ? 32'h0000_00FF : r_size == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_shift;
    assign w_lane  = bus.mem_rd >> w_shift;
    assign w_load  = r_size == 2'd0 ? {{24{!r_uns && w_lane[7]}}, w_lane[7:0]} :
                     r_size == 2'd1 ? {{16{!r_uns && w_lane[15]}}, w_lane[15:0]} : bus.mem_rd;
    assign w_merge = r_size == 2'd2 ? r_wdata : (bus.mem_rd & ~w_mask) | ((r_wdata << w_shift) & w_mask);
    assign bus.req_ready  = r_state == IDLE;
    assign bus.resp_valid = r_state == LDRESP || r_state == RESP || r_state == ERR;
`ifdef LSU_ERR_EN
    assign bus.resp_err   = r_state == ERR;
`else
    assign bus.resp_err   = 1'b0;
`endif
    assign bus.resp_rdata = r_state == LDRESP ? w_load : 32'h0;
    assign bus.mem_we     = r_state == WR && !reset;
    assign bus.mem_a      = (r_state == RD || r_state == WR) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_wd     = r_state == WR ? w_merge : 32'h0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed-vector bench for lsu_ctrl with a one-cycle synchronous-read word memory model.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] mem [0:63];
    lsu_ctrl_if bus();
    lsu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
        bus.mem_rd <= mem[bus.mem_a[7:2]];
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    // called in an idle cycle at the negedge; returns at the negedge of cycle 1
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = '0; bus.req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.resp_rdata); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.mem_a !== 32'h0) begin bad++; $display("FAIL rst_mem_a got=%h exp=0", bus.mem_a); end
        total++; if (bus.mem_wd !== 32'h0) begin bad++; $display("FAIL rst_mem_wd got=%h exp=0", bus.mem_wd); end
        reset = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_sw(input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, 3'b010, a, d);
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", bus.mem_we); end
        total++; if (bus.mem_a !== a) begin bad++; $display("FAIL sw_a got=%h exp=%h", bus.mem_a, a); end
        total++; if (bus.mem_wd !== d) begin bad++; $display("FAIL sw_wd got=%h exp=%h", bus.mem_wd, d); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL sw_early_resp got=%b exp=0", bus.resp_valid); end
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL sw_resp got=%b exp=1", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL sw_resp_fields got=%h/%b/%b exp=0/0/0", bus.resp_rdata, bus.resp_err, bus.mem_we); end
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", bus.req_ready); end
    endtask
    task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        total++; if (bus.mem_a !== {a[31:2], 2'b00} || bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL %s_rd got=a:%h we:%b rv:%b exp=a:%h we:0 rv:0", nm, bus.mem_a, bus.mem_we, bus.resp_valid, {a[31:2], 2'b00}); end
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL %s_resp got=%b exp=1", nm, bus.resp_valid); end
        total++; if (bus.resp_rdata !== exp) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, bus.resp_rdata, exp); end
        @(negedge clk);
    endtask
    task automatic test_loads();
        test_load("lw", 3'b010, 32'h10, 32'h8081_F2F3);
        test_load("lb", 3'b000, 32'h11, 32'hFFFF_FFF2);
        test_load("lbu", 3'b100, 32'h11, 32'h0000_00F2);
        test_load("lh", 3'b001, 32'h12, 32'hFFFF_8081);
        test_load("lhu", 3'b101, 32'h12, 32'h0000_8081);
        test_load("lb3", 3'b000, 32'h13, 32'hFFFF_FF80);
    endtask
    task automatic test_sb();
        issue(1'b1, 3'b000, 32'h13, 32'h0000_00AA);
        total++; if (bus.mem_a !== 32'h10 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL sb_rd got=a:%h we:%b exp=a:10 we:0", bus.mem_a, bus.mem_we); end
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'hAA81_F2F3) begin
            bad++; $display("FAIL sb_wr got=we:%b wd:%h exp=we:1 wd:aa81f2f3", bus.mem_we, bus.mem_wd); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL sb_early_resp got=%b exp=0", bus.resp_valid); end
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) begin
            bad++; $display("FAIL sb_resp got=rv:%b d:%h exp=rv:1 d:0", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL sb_ready got=%b exp=1", bus.req_ready); end
        test_load("sb_lw", 3'b010, 32'h10, 32'hAA81_F2F3);
    endtask
    task automatic test_misaligned();
        test_sw(32'h20, 32'h5566_7788);
        issue(1'b0, 3'b010, 32'h22, 32'h0);
`ifdef LSU_ERR_EN
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
            bad++; $display("FAIL mis_err got=rv:%b err:%b exp=rv:1 err:1", bus.resp_valid, bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL mis_fields got=d:%h we:%b exp=d:0 we:0", bus.resp_rdata, bus.mem_we); end
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL mis_idle got=rdy:%b rv:%b exp=rdy:1 rv:0", bus.req_ready, bus.resp_valid); end
`else
        total++; if (bus.mem_a !== 32'h20 || bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL mis_rd got=a:%h rv:%b exp=a:20 rv:0", bus.mem_a, bus.resp_valid); end
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin
            bad++; $display("FAIL mis_resp got=rv:%b err:%b exp=rv:1 err:0", bus.resp_valid, bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'h5566_7788) begin bad++; $display("FAIL mis_data got=%h exp=55667788", bus.resp_rdata); end
        @(negedge clk);
`endif
    endtask
    task automatic test_reset_wr();
        issue(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        total++; if (bus.mem_a !== 32'h10 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL rwr_rd got=a:%h we:%b exp=a:10 we:0", bus.mem_a, bus.mem_we); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rwr_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rwr_resp got=%b exp=0", bus.resp_valid); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL rwr_after got=rdy:%b rv:%b exp=rdy:1 rv:0", bus.req_ready, bus.resp_valid); end
        test_load("rwr_lw", 3'b010, 32'h10, 32'hAA81_F2F3);
    endtask
    task automatic test_back_to_back();
        int n = 0;
        logic rv = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h30; bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 bus.req_we = 1'b0; bus.req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_wr got=we:%b wd:%h exp=we:1 wd:12345678", bus.mem_we, bus.mem_wd); end
        while (bus.req_ready !== 1'b1 && n < 10) begin
            n++;
            rv = bus.resp_valid;
            @(negedge clk);
        end
        total++; if (n !== 2) begin bad++; $display("FAIL b2b_busy got=%0d exp=2", n); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL b2b_resp_before_ready got=%b exp=1", rv); end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_a !== 32'h30 || bus.mem_we !== 1'b0 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_second got=a:%h we:%b rdy:%b exp=a:30 we:0 rdy:0", bus.mem_a, bus.mem_we, bus.req_ready); end
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_data got=rv:%b d:%h exp=rv:1 d:12345678", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask
    initial begin
        test_reset();
        test_sw(32'h10, 32'h8081_F2F3);
        test_loads();
        test_sb();
        test_misaligned();
        test_reset_wr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
